// File: rtl/layer3_search_stage.sv
// Layer-3 bitmap search stage: reads one 16-bit node bitmap and selects the lowest set bit
// at or above a start position, producing the layer-4 child address.
module layer3_search_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_node_addr,
    input  logic [3:0]  in_start_idx,
    output logic        mem_ena,
    output logic [7:0]  mem_node_addr,
    input  logic [15:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hit,
    output logic [3:0]  out_idx,
    output logic [11:0] out_child_addr,
    output logic [15:0] miss_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e      state_q, state_d;
    logic [7:0]  node_q, node_d;
    logic [3:0]  start_q, start_d;
    logic        hit_q, hit_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    logic [15:0] mask;
    logic        mask_hit;
    logic [3:0]  mask_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Eligible bits only; descending scan leaves the lowest set position in mask_idx.
    always_comb begin
        mask     = mem_data & (16'hFFFF << start_q);
        mask_hit = |mask;
        mask_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                mask_idx = 4'(i);
            end
        end
    end

    // Datapath next-state
    always_comb begin
        node_d     = node_q;
        start_d    = start_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == StIdle && in_valid) begin
            node_d  = in_node_addr;
            start_d = in_start_idx;
        end
        if (state_q == StWait) begin
            hit_d = mask_hit;
            idx_d = mask_hit ? mask_idx : 4'd0;
            if (!mask_hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q     <= '0;
            start_q    <= '0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            miss_cnt_q <= '0;
        end else begin
            node_q     <= node_d;
            start_q    <= start_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Outputs
    always_comb begin
        in_ready       = (state_q == StIdle);
        mem_ena        = (state_q == StIssue);
        out_valid      = (state_q == StOut);
        mem_node_addr  = node_q;
        out_hit        = hit_q;
        out_idx        = idx_q;
        out_child_addr = {node_q, idx_q};
        miss_cnt       = miss_cnt_q;
    end

endmodule
